pipeline_ctrl: RTL and testbench

Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Produces per-stage write enables, bubble and flush controls. Arbitrates between three stall sources: a multi-cycle data-memory handshake, load-use hazards, and taken-branch/jump flushes. Also provides a memory-timeout watchdog and a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_hazard_detect.sv | 24 ++
 rtl/pipeline_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencer
//
// Contents:
//   state_t      sequencer state encoding
//   REG_ZERO     architectural zero register index
//   DEF_TIMEOUT  default memory watchdog limit (cycles)
//   DEF_CNT_W    default stall counter width
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERR      = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         DEF_TIMEOUT = 64;
    localparam int         DEF_CNT_W   = 16;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - load-use hazard comparator
//
// Ports:
//   idex_memrd_i  ID/EX holds a load
//   idex_rt_i     load destination register
//   ifid_rs_i     IF/ID first source register
//   ifid_rt_i     IF/ID second source register
//   load_use_o    instruction in ID needs the load result that is still in EX
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       idex_memrd_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    output logic       load_use_o
);

    // A load into the zero register never produces a dependency.
    assign load_use_o = idex_memrd_i
                      && (idex_rt_i != REG_ZERO)
                      && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline register / PC sequencer with stall arbitration
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-low reset
//   start_i                      run enable
//   idex_memrd_i, idex_rt_i      load in EX and its destination
//   ifid_rs_i, ifid_rt_i         sources of the instruction in ID
//   branch_taken_i, jump_i       control transfer resolved in ID
//   exmem_memrd_i/_memwr_i       memory op in MEM stage
//   mem_ack_i                    data memory completion
//   mem_req_o                    data memory request
//   pc_we_o, ifid_we_o           PC / IF/ID write enables
//   ifid_flush_o                 IF/ID clear
//   idex_bubble_o                ID/EX NOP insert
//   exmem_we_o                   EX/MEM and ID/EX write enable
//   memwb_bubble_o               MEM/WB NOP insert
//   err_o                        memory timeout error (sticky until reset)
//   stall_cnt_o                  saturating stalled-cycle count
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memrd_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             exmem_memrd_i,
    input  logic             exmem_memwr_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_we_o,
    output logic             memwb_bubble_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Wait counter only needs to reach TIMEOUT-1: the cycle at that value
    // is the last MEM_WAIT cycle before ERR.
    localparam int               WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mem_op;
    logic              run_flow;

    assign mem_op = exmem_memrd_i | exmem_memwr_i;

    hazard_detect u_hazard_detect (
        .idex_memrd_i (idex_memrd_i),
        .idex_rt_i    (idex_rt_i),
        .ifid_rs_i    (ifid_rs_i),
        .ifid_rt_i    (ifid_rt_i),
        .load_use_o   (load_use)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            stall_cnt_o <= '0;
        end else begin
            state <= state_next;

            if (state == S_MEM_WAIT && state_next == S_MEM_WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if ((state == S_RUN || state == S_MEM_WAIT) && !pc_we_o
                && stall_cnt_o != {CNT_W{1'b1}}) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next     = state;
        run_flow       = 1'b0;
        mem_req_o      = 1'b0;
        pc_we_o        = 1'b0;
        ifid_we_o      = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_we_o     = 1'b0;
        memwb_bubble_o = 1'b0;
        err_o          = 1'b0;

        case (state)
            S_IDLE: begin
                idex_bubble_o  = 1'b1;
                memwb_bubble_o = 1'b1;
                if (start_i) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                mem_req_o = mem_op;
                if (mem_op && !mem_ack_i) begin
                    // Freeze outranks load-use and flush; a pending branch
                    // stays in ID and is re-evaluated after the release.
                    memwb_bubble_o = 1'b1;
                    state_next     = S_MEM_WAIT;
                end else begin
                    run_flow = 1'b1;
                    if (!start_i) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_MEM_WAIT: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    // Release in the ack cycle itself: behaves as a RUN cycle.
                    run_flow   = 1'b1;
                    state_next = start_i ? S_RUN : S_IDLE;
                end else begin
                    memwb_bubble_o = 1'b1;
                    if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                        state_next = S_ERR;
                    end
                end
            end
            S_ERR: begin
                idex_bubble_o  = 1'b1;
                memwb_bubble_o = 1'b1;
                err_o          = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (run_flow) begin
            exmem_we_o = 1'b1;
            if (load_use) begin
                idex_bubble_o = 1'b1;
            end else begin
                pc_we_o      = 1'b1;
                ifid_we_o    = 1'b1;
                ifid_flush_o = branch_taken_i | jump_i;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed vector bench for pipeline_ctrl
module tb_pipeline_ctrl;

    // Output bundle order: {req, pc_we, ifid_we, flush, idex_bub, exmem_we, memwb_bub, err}
    localparam logic [7:0] O_IDLE = 8'b0_0_0_0_1_0_1_0;
    localparam logic [7:0] O_RUN  = 8'b0_1_1_0_0_1_0_0;
    localparam logic [7:0] O_LU   = 8'b0_0_0_0_1_1_0_0;
    localparam logic [7:0] O_FL   = 8'b0_1_1_1_0_1_0_0;
    localparam logic [7:0] O_FRZ  = 8'b1_0_0_0_0_0_1_0;
    localparam logic [7:0] O_ACK  = 8'b1_1_1_0_0_1_0_0;
    localparam logic [7:0] O_ERR  = 8'b0_0_0_0_1_0_1_1;

    typedef struct {
        logic       rst;
        logic       start;
        logic       memrd;
        logic [4:0] rt;
        logic [4:0] rs;
        logic [4:0] ifrt;
        logic       br;
        logic       jmp;
        logic       exrd;
        logic       exwr;
        logic       ack;
        logic [7:0] exp_o;
        logic [3:0] exp_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       idex_memrd = 1'b0;
    logic [4:0] idex_rt = '0;
    logic [4:0] ifid_rs = '0;
    logic [4:0] ifid_rt = '0;
    logic       branch_taken = 1'b0;
    logic       jump = 1'b0;
    logic       exmem_memrd = 1'b0;
    logic       exmem_memwr = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble, err;
    logic [3:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .idex_memrd_i   (idex_memrd),
        .idex_rt_i      (idex_rt),
        .ifid_rs_i      (ifid_rs),
        .ifid_rt_i      (ifid_rt),
        .branch_taken_i (branch_taken),
        .jump_i         (jump),
        .exmem_memrd_i  (exmem_memrd),
        .exmem_memwr_i  (exmem_memwr),
        .mem_ack_i      (mem_ack),
        .mem_req_o      (mem_req),
        .pc_we_o        (pc_we),
        .ifid_we_o      (ifid_we),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .exmem_we_o     (exmem_we),
        .memwb_bubble_o (memwb_bubble),
        .err_o          (err),
        .stall_cnt_o    (stall_cnt)
    );

    function automatic vec_t mk(input logic r, input logic s, input logic mrd, input logic [4:0] t,
                                input logic [4:0] rs_v, input logic [4:0] rt_v, input logic b,
                                input logic j, input logic erd, input logic ewr, input logic a,
                                input logic [7:0] eo, input logic [3:0] ec);
        vec_t v;
        v.rst = r; v.start = s; v.memrd = mrd; v.rt = t; v.rs = rs_v; v.ifrt = rt_v;
        v.br = b; v.jmp = j; v.exrd = erd; v.exwr = ewr; v.ack = a;
        v.exp_o = eo; v.exp_cnt = ec;
        return v;
    endfunction

    // Drive one cycle's inputs just after the edge, compare at the falling edge.
    task automatic apply(input vec_t v, input string name);
        logic [7:0] got;
        @(posedge clk);
        #1;
        rst = v.rst; start = v.start; idex_memrd = v.memrd; idex_rt = v.rt;
        ifid_rs = v.rs; ifid_rt = v.ifrt; branch_taken = v.br; jump = v.jmp;
        exmem_memrd = v.exrd; exmem_memwr = v.exwr; mem_ack = v.ack;
        @(negedge clk);
        got = {mem_req, pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble, err};
        checks++;
        if (got !== v.exp_o) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b", name, got, v.exp_o);
        end
        checks++;
        if (stall_cnt !== v.exp_cnt) begin
            errors++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", name, stall_cnt, v.exp_cnt);
        end
    endtask

    initial begin
        //            rst st mrd rt  rs  irt br jp erd ewr ack  outputs cnt
        vecs.push_back(mk(0, 1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_IDLE, 0)); // reset held
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_IDLE, 0)); // IDLE, start seen
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_RUN,  0)); // RUN no hazard
        vecs.push_back(mk(1, 1, 1, 8,  8,  0,  0, 0, 0, 0, 0, O_LU,   0)); // load-use on rs
        vecs.push_back(mk(1, 1, 1, 0,  0,  0,  0, 0, 0, 0, 0, O_RUN,  1)); // rt=0: no stall
        vecs.push_back(mk(1, 1, 1, 9,  3,  9,  0, 0, 0, 0, 0, O_LU,   1)); // load-use on rt
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 1, 0, 0, 0, O_FL,   2)); // jump flush
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 1, 0, O_FRZ,  2)); // store, no ack
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 1, 0, O_FRZ,  3)); // MEM_WAIT
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 1, 0, O_FRZ,  4)); // MEM_WAIT
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 1, 1, O_ACK,  5)); // ack releases
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 1, 0, 1, O_ACK,  5)); // zero-wait load
        vecs.push_back(mk(1, 1, 1, 4,  4,  0,  1, 0, 0, 0, 0, O_LU,   5)); // branch + load-use
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  1, 0, 0, 0, 0, O_FL,   6)); // branch retried
        vecs.push_back(mk(1, 0, 0, 0,  0,  0,  0, 0, 1, 0, 0, O_FRZ,  6)); // stop with pending load
        vecs.push_back(mk(1, 0, 0, 0,  0,  0,  0, 0, 1, 0, 1, O_ACK,  7)); // access completes
        vecs.push_back(mk(1, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_IDLE, 7)); // back in IDLE
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_IDLE, 7)); // restart
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 1, 0, O_FRZ,  7)); // store never acked
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 4'(8 + k))); // 4 waits
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 1, 0, O_ERR, 12)); // ERR
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 0, 1, O_ERR, 12)); // late ack ignored
        vecs.push_back(mk(0, 1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_ERR, 12)); // reset sampled here
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_IDLE, 0)); // IDLE, err cleared
        for (int k = 0; k < 20; k++)
            vecs.push_back(mk(1, 1, 1, 7, 7, 0, 0, 0, 0, 0, 0, O_LU, (k > 15) ? 4'd15 : 4'(k)));
        vecs.push_back(mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_RUN, 15)); // saturated

        rst = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset arriving mid-MEM_WAIT returns to IDLE with counter cleared.
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ, 15), "rstwait_freeze");
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ, 15), "rstwait_wait");
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ, 15), "rstwait_assert");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE, 0), "rstwait_idle");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0), "rstwait_stay");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
